pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer and instruction memory.
// Latency: none (wires only).
// Backpressure: memory signals acceptance with imem_ready; the requester holds its address until then.
//
// Signals: imem_req/imem_addr (sequencer -> memory), imem_ready/opcode (memory -> sequencer).
interface pc_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [6:0]       opcode;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  opcode
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output opcode
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: walks instruction memory from address 0 until a halt opcode.
// Latency: one cycle from an accepted instruction to the instr_valid pulse and count update.
// Backpressure: stall parks the block in WAIT with imem_req low; imem_ready is then ignored.
//
// Ports: clk, rst (async active-low), start, stall, redirect/redirect_addr,
//        imem (fetch bus, master side), instr_valid, halted, fetch_count (saturating).
module pc_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [6:0] HALT_OP = 7'b1111111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WIDTH-1:0]     redirect_addr,
  pc_sequencer_if.master       imem,
  output logic                 instr_valid,
  output logic                 halted,
  output logic [15:0]          fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    WAIT  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;

  // Request depends on state only, so there is no path from imem_ready to imem_req.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign halted         = (state_q == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      // instr_valid is a single-cycle pulse; it is only raised on an acceptance below.
      instr_valid <= 1'b0;

      case (state_q)
        IDLE, HALT: begin
          // Redirect is deliberately not looked at here; only start leaves these states.
          if (start) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            fetch_count <= '0;
          end
        end

        FETCH: begin
          if (redirect) begin
            // A response arriving alongside a redirect belongs to the old path: drop it.
            pc_q    <= redirect_addr;
            state_q <= stall ? WAIT : FETCH;
          end else if (stall) begin
            state_q <= WAIT;
          end else if (imem.imem_ready) begin
            instr_valid <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
              fetch_count <= fetch_count + 16'd1;
            end
            if (imem.opcode == HALT_OP) begin
              // PC stays on the halt instruction so it can be inspected afterwards.
              state_q <= HALT;
            end else begin
              pc_q <= pc_q + WIDTH'(1);
            end
          end
        end

        WAIT: begin
          if (redirect) begin
            pc_q <= redirect_addr;
          end
          if (!stall) begin
            state_q <= FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
